an13_corrector: RTL
===================

AN13_CORRECTOR -- requirements
Module: an13_corrector

Interface
REQ-001 Parameter CNT_W, default 8, is the width of each statistics counter.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port in_valid, input, 1 bit: upstream Barrett decoder result is valid.
REQ-005 Port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-006 Port receive_in, input, 6 bits: received AN codeword (A=13).
REQ-007 Port q_in, input, 3 bits: floor(receive_in/13) from upstream.
REQ-008 Port r_in, input, 4 bits: receive_in mod 13 from upstream.
REQ-009 Port error_in, input, 1 bit: upstream nonzero-residue flag.
REQ-010 Port out_valid, output, 1 bit: the output word is valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the output.
REQ-012 Port data_out, output, 3 bits: decoded data.
REQ-013 Port codeword_out, output, 6 bits: corrected codeword.
REQ-014 Port corrected, output, 1 bit: a single arithmetic error was corrected.
REQ-015 Port uncorrectable, output, 1 bit: the error could not be corrected.
REQ-016 Port cnt_clr, input, 1 bit: synchronous clear of all counters.
REQ-017 Ports err_cnt, corr_cnt and uncorr_cnt, outputs, CNT_W bits each: saturating event counters.

Function
REQ-018 The block SHALL be a 2-stage pipeline: S1 registers the inputs plus the syndrome lookup; S2 registers the correction result; latency is 2 cycles with no stall.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance, forced to 0 while rst_n is low; both stages shift only when advance is 1.
REQ-020 A transfer SHALL occur on in_valid && in_ready; S1 valid loads in_valid on advance; bubbles propagate as invalid.
REQ-021 While out_valid=1 && out_ready=0, all output ports SHALL hold stable.
REQ-022 Syndrome table, residue -> error e: 1->+1, 2->+2, 4->+4, 8->+8, 3->+16, 6->+32, 12->-1, 11->-2, 9->-4, 5->-8, 10->-16, 7->-32.
REQ-023 If error_in=0 and r_in=0: codeword_out=receive_in, data_out=q_in, corrected=0, uncorrectable=0.
REQ-024 If r_in is in 1..12: compute c = receive_in - e with 7-bit signed arithmetic. If 0<=c<=63: codeword_out=c, data_out=c/13 (exact), corrected=1.
REQ-025 If r_in is in 13..15, c<0, c>63, or error_in disagrees with (r_in!=0): uncorrectable=1, corrected=0, codeword_out=receive_in, data_out=q_in.
REQ-026 data_out SHALL always be in 0..4 for corrected words.
REQ-027 On each output transfer (out_valid && out_ready), the counters SHALL update:
- err_cnt increments if the word had error_in=1 or r_in!=0.
- corr_cnt increments if corrected=1.
- uncorr_cnt increments if uncorrectable=1.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 cnt_clr=1 SHALL zero all counters next edge; cnt_clr wins over a simultaneous increment.

Reset
REQ-030 While rst_n=0: out_valid, data_out, codeword_out, corrected, uncorrectable, all counters and internal stage valids SHALL be 0; in_ready SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight words without counting them; the first acceptance occurs on the first clk edge after rst_n rises.

Verification
REQ-032 receive=26, q=2, r=0, err=0, out_ready=1 -> 2 cycles later: data_out=2, codeword_out=26, corrected=0; counters unchanged.
REQ-033 Correction cases:
- receive=27, q=2, r=1, err=1 -> codeword_out=26, data_out=2, corrected=1.
- receive=45, q=3, r=6 -> codeword_out=13, data_out=1.
- receive=20, q=1, r=7 -> codeword_out=52, data_out=4.
REQ-034 receive=63, q=4, r=11, err=1 -> uncorrectable=1, codeword_out=63, data_out=4; uncorr_cnt+1, err_cnt+1.
REQ-035 Stream 3 words with out_ready=0 for 4 cycles -> in_ready=0 after the pipeline fills, outputs hold stable, no loss, in-order delivery once out_ready=1.
REQ-036 Preload err_cnt to 255 (CNT_W=8) with an error word -> stays 255; cnt_clr plus a simultaneous error transfer -> all counters 0.
REQ-037 Assert rst_n low with 2 words in flight -> out_valid=0 immediately; counters 0; no stale word emitted after release.

Source files
------------

// File: rtl/an13_corrector.sv
// Two-stage AN (A=13) single-error corrector with saturating statistics counters.
// Stage 1 registers the Barrett result plus syndrome lookup; stage 2 registers the correction.
module an13_corrector #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       receive_in,
    input  logic [2:0]       q_in,
    input  logic [3:0]       r_in,
    input  logic             error_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       data_out,
    output logic [5:0]       codeword_out,
    output logic             corrected,
    output logic             uncorrectable,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic advance;
    logic xfer;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && rst_n;
    assign xfer     = out_valid && out_ready;

    // Syndrome lookup: residue -> signed error value e (two's complement, 7 bits)
    logic       syn_hit;
    logic [6:0] syn_e;

    always_comb begin
        syn_hit = 1'b1;
        syn_e   = 7'd0;
        case (r_in)
            4'd1:    syn_e = 7'd1;
            4'd2:    syn_e = 7'd2;
            4'd4:    syn_e = 7'd4;
            4'd8:    syn_e = 7'd8;
            4'd3:    syn_e = 7'd16;
            4'd6:    syn_e = 7'd32;
            4'd12:   syn_e = 7'h7f;  // -1
            4'd11:   syn_e = 7'h7e;  // -2
            4'd9:    syn_e = 7'h7c;  // -4
            4'd5:    syn_e = 7'h78;  // -8
            4'd10:   syn_e = 7'h70;  // -16
            4'd7:    syn_e = 7'h60;  // -32
            default: syn_hit = 1'b0;
        endcase
    end

    logic       s1_valid;
    logic [5:0] s1_recv;
    logic [2:0] s1_q;
    logic       s1_err;
    logic       s1_rnz;
    logic       s1_hit;
    logic [6:0] s1_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_recv  <= '0;
            s1_q     <= '0;
            s1_err   <= 1'b0;
            s1_rnz   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_e     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_recv  <= receive_in;
            s1_q     <= q_in;
            s1_err   <= error_in;
            s1_rnz   <= (r_in != 4'd0);
            s1_hit   <= syn_hit;
            s1_e     <= syn_e;
        end
    end

    // c = receive - e, computed 8 bits wide so the 0..63 range test is a plain top-bits check
    logic [7:0] c_val;
    logic       c_ok;
    logic [2:0] c_div;
    logic [2:0] nxt_data;
    logic [5:0] nxt_cw;
    logic       nxt_corr;
    logic       nxt_unc;

    assign c_val = {2'b00, s1_recv} - {s1_e[6], s1_e};
    assign c_ok  = (c_val[7:6] == 2'b00);

    always_comb begin
        if (c_val[5:0] >= 6'd52)      c_div = 3'd4;
        else if (c_val[5:0] >= 6'd39) c_div = 3'd3;
        else if (c_val[5:0] >= 6'd26) c_div = 3'd2;
        else if (c_val[5:0] >= 6'd13) c_div = 3'd1;
        else                          c_div = 3'd0;
    end

    always_comb begin
        nxt_data = s1_q;
        nxt_cw   = s1_recv;
        nxt_corr = 1'b0;
        nxt_unc  = 1'b0;
        if (!s1_err && !s1_rnz) begin
            nxt_unc = 1'b0;
        end else if ((s1_err == s1_rnz) && s1_hit && c_ok) begin
            nxt_data = c_div;
            nxt_cw   = c_val[5:0];
            nxt_corr = 1'b1;
        end else begin
            nxt_unc = 1'b1;
        end
    end

    logic s2_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            data_out      <= '0;
            codeword_out  <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            s2_err        <= 1'b0;
        end else if (advance) begin
            out_valid     <= s1_valid;
            data_out      <= nxt_data;
            codeword_out  <= nxt_cw;
            corrected     <= nxt_corr;
            uncorrectable <= nxt_unc;
            s2_err        <= s1_err || s1_rnz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt    <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (xfer) begin
            if (s2_err && (err_cnt != '1))          err_cnt    <= err_cnt + CNT_W'(1);
            if (corrected && (corr_cnt != '1))      corr_cnt   <= corr_cnt + CNT_W'(1);
            if (uncorrectable && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule
